mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//   Sequences every MEM-stage load/store onto a handshaked data memory: one transaction at a time.
//   Derives byte enables and lane-replicated store data, and checks alignment.
//   Waits for the memory acknowledge, with a timeout, then returns load data through the
//   sign/zero extension unit. Sits between the pipeline MEM stage and the data memory port.
// PARAMETERS
//   TIMEOUT   16   max cycles in WAIT before the transaction is aborted with error (>=1)
//   CNT_W     5    width of the timeout counter; must hold TIMEOUT
// PORTS
//   clk          in   1   clock; all state updates on posedge
//   rst_n        in   1   asynchronous, active-low reset
//   req_valid    in   1   MEM stage presents a load/store
//   req_ready    out  1   controller can accept a request (1 only in IDLE)
//   req_we       in   1   1=store, 0=load
//   req_addr     in   32  byte address
//   req_wdata    in   32  store data, right-justified
//   req_ld_op    in   3   000 lw, 001 lbu, 010 lb, 011 lhu, 100 lh; others illegal
//   req_st_size  in   2   00 sw, 01 sh, 10 sb; 11 illegal
//   resp_valid   out  1   one-cycle pulse: transaction finished
//   resp_rdata   out  32  extended load data (0 for stores or on error)
//   resp_err     out  1   valid with resp_valid: misaligned, illegal op, or timeout
//   busy         out  1   state != IDLE; drives the pipeline stall
//   mem_req      out  1   memory request, held until mem_ack
//   mem_we       out  1   memory write
//   mem_addr     out  32  word address: {addr[31:2],2'b00}
//   mem_be       out  4   byte enables (all ones for loads)
//   mem_wdata    out  32  lane-replicated store data
//   mem_ack      in   1   memory completes the request this cycle
//   mem_rdata    in   32  read word, valid with mem_ack
// BEHAVIOUR
//   Reset: state=IDLE. All outputs 0 except req_ready=1. Timeout counter=0.
//   FSM IDLE -> WAIT | RESP; WAIT -> RESP; RESP -> IDLE.
//   IDLE: on req_valid, capture op/addr/data.
//     If misaligned (word: addr[1:0]!=0; half: addr[0]!=0) or op illegal: go to RESP, err=1.
//     Otherwise go to WAIT; counter=0.
//   WAIT: mem_req=1. mem_we/addr/be/wdata come from registers and are stable until ack.
//     mem_ack=1: for a load, register load_align_ext(mem_rdata, addr[1:0], ld_op); go to RESP.
//     Otherwise counter++. When counter==TIMEOUT-1 with no ack: drop mem_req, go to RESP, err=1.
//   RESP: resp_valid=1 for exactly one cycle, then return to IDLE.
//     Registered rdata/err are driven on resp_rdata/resp_err.
//   Latency: accept at cycle N; mem_req at N+1. With mem_ack at N+1, resp_valid at N+2.
//     Error path: resp_valid at N+1 with no mem_req.
//   Byte enables: sw 1111; sh 0011 (addr[1]=0) / 1100 (addr[1]=1);
//     sb 0001<<addr[1:0].
//   Store data: sw as-is; sh {2{wdata[15:0]}}; sb {4{wdata[7:0]}}.
//   Load extension: lw passthrough; lbu/lhu zero-extend; lb/lh sign-extend.
//     Byte lane is selected by addr[1:0]; halfword lane by addr[1].
//   mem_ack outside WAIT is ignored. No request is accepted in WAIT or RESP.
//   Back-to-back: a new request may be accepted in the IDLE cycle right after RESP.
//   Reset mid-transaction: mem_req and resp_valid go to 0 immediately.
//     Any pending ack is lost. req_ready=1 from the first clock after release.
// STRUCTURE
//   Package mem_ctrl_pkg:
//     LD_W/LD_BU/LD_B/LD_HU/LD_H codes; ST_W/ST_H/ST_B codes;
//     state encoding IDLE/WAIT/RESP (2 bits).
//   Sub-module load_align_ext: combinational extension of a 32-bit word by op and addr[1:0].
//   The FSM, counter, byte-enable and store-lane logic stay in this module.
// TESTING
//   lb addr 0x1003, mem_rdata 0x80FF1234, ack at first WAIT cycle
//     -> resp_rdata 0xFFFFFF80, err 0, resp_valid 2 cycles after accept.
//   sh addr 0x1002, wdata 0x0000ABCD -> mem_be 1100, mem_wdata 0xABCDABCD,
//     mem_addr 0x1000, mem_we 1.
//   lw addr 0x1002 -> no mem_req, resp_valid next cycle, resp_err 1, resp_rdata 0.
//   lhu addr 0x2000, mem_ack withheld
//     -> mem_req high TIMEOUT cycles then low, resp_err 1.
//   rst_n low during WAIT -> mem_req 0 same cycle.
//     After release: req_ready 1, late mem_ack ignored, no resp_valid.
//   Back-to-back sb 0x3001 (wdata 0x5A) then lbu 0x3001, rdata 0x00005A00
//     -> be 0010, then resp_rdata 0x0000005A.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and store/alignment helpers for the data-memory access controller.
package mem_ctrl_pkg;

  // Load operation codes (req_ld_op)
  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_BU = 3'b001;
  localparam logic [2:0] LD_B  = 3'b010;
  localparam logic [2:0] LD_HU = 3'b011;
  localparam logic [2:0] LD_H  = 3'b100;

  // Store size codes (req_st_size)
  localparam logic [1:0] ST_W = 2'b00;
  localparam logic [1:0] ST_H = 2'b01;
  localparam logic [1:0] ST_B = 2'b10;

  // Controller state encoding
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  // Load codes above LD_H and store size 11 have no meaning.
  function automatic logic op_illegal(input logic we, input logic [2:0] ld_op,
                                      input logic [1:0] st_size);
    logic bad;
    bad = 1'b0;
    if (we) begin
      bad = (st_size == 2'b11);
    end else begin
      bad = (ld_op > LD_H);
    end
    return bad;
  endfunction

  // Words need addr[1:0]==0, halfwords need addr[0]==0, bytes are always aligned.
  function automatic logic misaligned(input logic we, input logic [2:0] ld_op,
                                      input logic [1:0] st_size, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    if (we) begin
      case (st_size)
        ST_W:    mis = (lo != 2'b00);
        ST_H:    mis = lo[0];
        default: mis = 1'b0;
      endcase
    end else begin
      case (ld_op)
        LD_W:         mis = (lo != 2'b00);
        LD_HU, LD_H:  mis = lo[0];
        default:      mis = 1'b0;
      endcase
    end
    return mis;
  endfunction

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] store_be(input logic [1:0] st_size, input logic [1:0] lo);
    logic [3:0] be;
    be = 4'b0000;
    case (st_size)
      ST_W:    be = 4'b1111;
      ST_H:    be = lo[1] ? 4'b1100 : 4'b0011;
      ST_B:    be = 4'b0001 << lo;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the right-justified store data into every lane so the enables pick the right one.
  function automatic logic [31:0] store_lanes(input logic [1:0] st_size, input logic [31:0] wdata);
    logic [31:0] lanes;
    lanes = 32'h0000_0000;
    case (st_size)
      ST_W:    lanes = wdata;
      ST_H:    lanes = {2{wdata[15:0]}};
      ST_B:    lanes = {4{wdata[7:0]}};
      default: lanes = 32'h0000_0000;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Selects the addressed byte/halfword lane of a read word and zero/sign-extends it.
module load_align_ext
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lo,
  input  logic [2:0]  ld_op,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection: byte by lo[1:0], halfword by lo[1].
  always_comb begin
    byte_sel = 8'h00;
    case (lo)
      2'b00:   byte_sel = word[7:0];
      2'b01:   byte_sel = word[15:8];
      2'b10:   byte_sel = word[23:16];
      2'b11:   byte_sel = word[31:24];
      default: byte_sel = 8'h00;
    endcase
    if (lo[1]) begin
      half_sel = word[31:16];
    end else begin
      half_sel = word[15:0];
    end
  end

  // Extension according to the load operation; illegal codes yield zero.
  always_comb begin
    data = 32'h0000_0000;
    case (ld_op)
      LD_W:    data = word;
      LD_BU:   data = {24'h00_0000, byte_sel};
      LD_B:    data = {{24{byte_sel[7]}}, byte_sel};
      LD_HU:   data = {16'h0000, half_sel};
      LD_H:    data = {{16{half_sel[15]}}, half_sel};
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences single MEM-stage loads/stores onto a handshaked data memory with timeout.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_ld_op,
  input  logic [1:0]  req_st_size,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       ld_op_r;
  logic [1:0]       addr_lo_r;

  logic             req_bad_s;
  logic [3:0]       req_be_s;
  logic [31:0]      req_lanes_s;
  logic [31:0]      ext_data_s;

  // Request decode: rejection reason, byte enables and replicated store data.
  always_comb begin
    req_bad_s = op_illegal(req_we, req_ld_op, req_st_size) |
                misaligned(req_we, req_ld_op, req_st_size, req_addr[1:0]);
    if (req_we) begin
      req_be_s    = store_be(req_st_size, req_addr[1:0]);
      req_lanes_s = store_lanes(req_st_size, req_wdata);
    end else begin
      req_be_s    = 4'b1111;
      req_lanes_s = 32'h0000_0000;
    end
  end

  // Extension of the returned word uses the lane/op captured at accept time.
  load_align_ext u_load_align_ext (
    .word  (mem_rdata),
    .lo    (addr_lo_r),
    .ld_op (ld_op_r),
    .data  (ext_data_s)
  );

  // Transaction FSM with timeout counter; every output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      ld_op_r    <= 3'b000;
      addr_lo_r  <= 2'b00;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0000_0000;
      resp_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0000_0000;
      mem_be     <= 4'b0000;
      mem_wdata  <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            ld_op_r   <= req_ld_op;
            addr_lo_r <= req_addr[1:0];
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_bad_s) begin
              // Rejected requests never reach the memory port.
              state_r    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0000_0000;
            end else begin
              state_r   <= WAIT;
              cnt_r     <= '0;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= req_be_s;
              mem_wdata <= req_lanes_s;
            end
          end else begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            state_r    <= RESP;
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= mem_we ? 32'h0000_0000 : ext_data_s;
          end else if (cnt_r == CNT_LAST) begin
            state_r    <= RESP;
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'h0000_0000;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        RESP: begin
          // Single-cycle response pulse, then ready for the next request.
          state_r    <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0000_0000;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          mem_req    <= 1'b0;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0000_0000;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl.
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_ld_op;
  logic [1:0]  req_st_size;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ld_op   (req_ld_op),
    .req_st_size (req_st_size),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .busy        (busy),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_load(input logic [31:0] addr, input logic [2:0] op);
    req_valid   = 1'b1;
    req_we      = 1'b0;
    req_addr    = addr;
    req_ld_op   = op;
    req_st_size = 2'b00;
    req_wdata   = 32'h0;
  endtask

  task automatic set_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd);
    req_valid   = 1'b1;
    req_we      = 1'b1;
    req_addr    = addr;
    req_ld_op   = 3'b000;
    req_st_size = sz;
    req_wdata   = wd;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_ld_op = 3'b000; req_st_size = 2'b00; mem_ack = 1'b0; mem_rdata = 32'h0;

    // Reset state
    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    rst_n = 1'b1;
    tick();

    // lb 0x1003, ack in first WAIT cycle
    set_load(32'h0000_1003, 3'b010);
    tick();
    req_valid = 1'b0;
    chk("lb_mem_req", {31'd0, mem_req}, 32'd1);
    chk("lb_mem_addr", mem_addr, 32'h0000_1000);
    chk("lb_mem_be", {28'd0, mem_be}, 32'h0000_000F);
    chk("lb_mem_we", {31'd0, mem_we}, 32'd0);
    chk("lb_busy", {31'd0, busy}, 32'd1);
    chk("lb_req_ready", {31'd0, req_ready}, 32'd0);
    chk("lb_no_resp_yet", {31'd0, resp_valid}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
    tick();
    mem_ack = 1'b0;
    chk("lb_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("lb_resp_rdata", resp_rdata, 32'hFFFF_FF80);
    chk("lb_resp_err", {31'd0, resp_err}, 32'd0);
    chk("lb_mem_req_drop", {31'd0, mem_req}, 32'd0);
    tick();
    chk("lb_pulse_end", {31'd0, resp_valid}, 32'd0);
    chk("lb_ready_again", {31'd0, req_ready}, 32'd1);

    // sh 0x1002
    set_store(32'h0000_1002, 2'b01, 32'h0000_ABCD);
    tick();
    req_valid = 1'b0;
    chk("sh_mem_be", {28'd0, mem_be}, 32'h0000_000C);
    chk("sh_mem_wdata", mem_wdata, 32'hABCD_ABCD);
    chk("sh_mem_addr", mem_addr, 32'h0000_1000);
    chk("sh_mem_we", {31'd0, mem_we}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    chk("sh_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("sh_resp_rdata", resp_rdata, 32'h0);
    chk("sh_resp_err", {31'd0, resp_err}, 32'd0);
    tick();

    // lh 0x2002: upper halfword, sign-extended
    set_load(32'h0000_2002, 3'b100);
    tick();
    req_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h8001_7FFF;
    tick();
    mem_ack = 1'b0;
    chk("lh_resp_rdata", resp_rdata, 32'hFFFF_8001);
    tick();

    // lw 0x1002 misaligned: error next cycle, no memory request
    set_load(32'h0000_1002, 3'b000);
    tick();
    req_valid = 1'b0;
    chk("lwmis_mem_req", {31'd0, mem_req}, 32'd0);
    chk("lwmis_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("lwmis_resp_err", {31'd0, resp_err}, 32'd1);
    chk("lwmis_resp_rdata", resp_rdata, 32'h0);
    tick();
    chk("lwmis_pulse_end", {31'd0, resp_valid}, 32'd0);

    // Illegal load op and illegal store size
    set_load(32'h0000_0000, 3'b101);
    tick();
    req_valid = 1'b0;
    chk("ldill_resp_err", {31'd0, resp_err}, 32'd1);
    chk("ldill_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    set_store(32'h0000_0000, 2'b11, 32'h1234_5678);
    tick();
    req_valid = 1'b0;
    chk("still_resp_err", {31'd0, resp_err}, 32'd1);
    tick();

    // lhu 0x2000 with ack withheld: mem_req for TIMEOUT cycles, then error
    set_load(32'h0000_2000, 3'b011);
    tick();
    req_valid = 1'b0;
    chk("to_req_0", {31'd0, mem_req}, 32'd1);
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
      chk("to_req_hold", {31'd0, mem_req}, 32'd1);
    end
    tick();
    chk("to_req_drop", {31'd0, mem_req}, 32'd0);
    chk("to_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("to_resp_err", {31'd0, resp_err}, 32'd1);
    chk("to_resp_rdata", resp_rdata, 32'h0);
    tick();

    // Reset during WAIT
    set_load(32'h0000_4000, 3'b000);
    tick();
    req_valid = 1'b0;
    chk("rw_req_before", {31'd0, mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_req_async", {31'd0, mem_req}, 32'd0);
    chk("rw_resp_async", {31'd0, resp_valid}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    #3;
    rst_n = 1'b1;
    tick();
    chk("rw_ready", {31'd0, req_ready}, 32'd1);
    chk("rw_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("rw_no_req", {31'd0, mem_req}, 32'd0);
    mem_ack = 1'b0;
    tick();
    chk("rw_no_resp2", {31'd0, resp_valid}, 32'd0);
    chk("rw_idle", {31'd0, busy}, 32'd0);

    // Back-to-back: sb 0x3001 then lbu 0x3001
    set_store(32'h0000_3001, 2'b10, 32'h0000_005A);
    tick();
    chk("sb_mem_be", {28'd0, mem_be}, 32'h0000_0002);
    chk("sb_mem_wdata", mem_wdata, 32'h5A5A_5A5A);
    chk("sb_mem_addr", mem_addr, 32'h0000_3000);
    set_load(32'h0000_3001, 3'b001);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("sb_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("sb_resp_err", {31'd0, resp_err}, 32'd0);
    tick();
    chk("b2b_idle_ready", {31'd0, req_ready}, 32'd1);
    chk("b2b_not_taken_in_resp", {31'd0, mem_req}, 32'd0);
    tick();
    req_valid = 1'b0;
    chk("lbu_mem_req", {31'd0, mem_req}, 32'd1);
    chk("lbu_mem_we", {31'd0, mem_we}, 32'd0);
    chk("lbu_mem_be", {28'd0, mem_be}, 32'h0000_000F);
    mem_ack = 1'b1; mem_rdata = 32'h0000_5A00;
    tick();
    mem_ack = 1'b0;
    chk("lbu_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("lbu_resp_rdata", resp_rdata, 32'h0000_005A);
    tick();

    // Ack while idle is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_ignored", {31'd0, resp_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
